sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
// - Shares the single external SRAM port between the CPU data bus and the VGA image loader.
// - Fixed CPU priority with a VGA anti-starvation limit; one transaction per grant.
// - Per-transaction bus timeout.
// - Sits between the CPU memory stage / vga_control and the SRAM pin driver.
// - Replaces the direct vga_re/vga_addr/vga_data/vga_success wiring.
// PARAMETERS
// ADDR_W        23   external address width (byte address, 16-bit words)
// DATA_W        16   external data width
// STARVE_LIMIT  4    consecutive CPU grants while vga_re pending before VGA is forced
// SUCCESS_HOLD  3    cycles a *_success strobe is held high after completion (>=2)
// TIMEOUT       255  max cycles in a grant state waiting for mem_done
// PORTS
// clk          in   1       system clock (50 MHz video clock domain)
// rst          in   1       synchronous, active-low reset (0 = reset, sampled on posedge clk)
// cpu_re       in   1       CPU read request, level, held until cpu_success
// cpu_we       in   1       CPU write request, level, held until cpu_success
// cpu_addr     in   ADDR_W  CPU address
// cpu_wdata    in   DATA_W  CPU write data
// cpu_rdata    out  DATA_W  CPU read data, valid while cpu_success=1
// cpu_success  out  1       CPU completion strobe
// vga_re       in   1       loader read request, level
// vga_addr     in   ADDR_W  loader address
// vga_data     out  DATA_W  loader read data, valid while vga_success=1
// vga_success  out  1       loader completion strobe
// mem_re       out  1       external read command
// mem_we       out  1       external write command
// mem_addr     out  ADDR_W  external address
// mem_wdata    out  DATA_W  external write data
// mem_rdata    in   DATA_W  external read data, valid with mem_done
// mem_done     in   1       external completion, single-cycle pulse
// grant        out  2       01=CPU, 10=VGA, 00=none
// timeout_err  out  1       sticky; set on any timeout
// BEHAVIOUR
// - Reset (rst=0 at posedge): every output 0.
//   - State IDLE; starve_cnt, hold_cnt and wait_cnt cleared.
//   - Mid-transaction reset drops mem_re/mem_we on that edge; no success is issued.
// - FSM states: IDLE, CPU, VGA, HOLD. All outputs registered.
// - IDLE, arbitration on each edge:
//   - VGA if vga_re && (!(cpu_re|cpu_we) || starve_cnt==STARVE_LIMIT).
//   - Else CPU if cpu_re|cpu_we.
//   - Else stay in IDLE.
// - Entering CPU: latch cpu_addr, cpu_wdata and the op; drive mem_* from the latches. cpu_we wins if both cpu_re and cpu_we are set.
//   - If vga_re: starve_cnt++ (saturating). Entering VGA: starve_cnt cleared.
// - Latency: request sampled at edge N -> mem_re/mem_we high after edge N, i.e. in cycle N+1.
//   - Request inputs changing during a grant are ignored (latched values used).
// - CPU/VGA on mem_done=1:
//   - Capture mem_rdata (write ops: 0) into the granted requester's data output.
//   - Deassert mem_re/mem_we, go to HOLD, raise that requester's success.
//   - success rises the cycle after mem_done.
// - HOLD: success and data held stable for exactly SUCCESS_HOLD cycles, then success=0, grant=00, -> IDLE.
//   - Guarantees >=1 low cycle before the next success to the same requester.
//   - The vga_control write1/write2 split of a 16-bit word into two bytes needs >=2 high cycles.
// - Timeout: wait_cnt counts cycles in CPU/VGA.
//   - On wait_cnt==TIMEOUT without mem_done: drop mem_*, set timeout_err, -> IDLE, no success.
//   - Requester retries by keeping its request high.
//   - timeout_err is cleared only by reset.
// - mem_done outside CPU/VGA is ignored.
// - mem_done on the timeout edge: completion wins, no error.
// - Requester dropping its request mid-grant: the transaction still completes and success is still pulsed.
// - Widths: counters sized $clog2(param+1). Address passes through unmodified (no byte/word shift here).
// STRUCTURE
// - Shared package sram_arb_pkg: state encodings, GRANT_NONE/CPU/VGA constants, default ADDR_W/DATA_W.
// - Single flat module. A generic sub-module is not warranted.
// TESTING
// - CPU read only: cpu_re, cpu_addr=0x000100, mem_done 4 cycles later with mem_rdata=0xBEEF
//   -> mem_addr=0x000100; cpu_rdata=0xBEEF; cpu_success high exactly 3 cycles; grant 01 then 00.
// - Simultaneous cpu_re and vga_re held continuously, mem_done 2 cycles after each command
//   -> grants CPU x4, then VGA x1, repeating; vga_success pulses every 5th transaction.
// - VGA stream: vga_re held, vga_addr stepping by +2 on success
//   -> mem_addr sequence 0,2,4,...; vga_data matches mem_rdata per word; success low >=1 cycle between words.
// - Timeout: cpu_we, no mem_done -> after 255 cycles mem_we=0, timeout_err=1, no cpu_success; next request is re-granted.
// - Reset mid-grant: rst=0 while mem_re=1 -> next edge all outputs 0; a mem_done during reset produces no success.
// - cpu_re and cpu_we both set; cpu_addr changed mid-grant -> mem_we=1 only; mem_addr stays at the original latched value.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants for the SRAM port arbiter
//
// Purpose: FSM state encodings, grant codes and default bus widths used by
//          the arbiter, its interface and the testbench.
// Ports:   none (package).

package sram_arb_pkg;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_VGA  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_VGA  = 2'b10;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - bus bundle between requesters, arbiter and SRAM driver
//
// Purpose: groups the CPU request, VGA loader request, external SRAM command
//          and status signals of the arbiter.
// Ports (signals):
//   cpu_re/cpu_we/cpu_addr/cpu_wdata   CPU request side (level requests)
//   cpu_rdata/cpu_success              CPU completion
//   vga_re/vga_addr                    loader request side
//   vga_data/vga_success               loader completion
//   mem_re/mem_we/mem_addr/mem_wdata   external SRAM command
//   mem_rdata/mem_done                 external SRAM completion
//   grant/timeout_err                  status
// Modports: slave  - the arbiter's view
//           master - the surrounding system's view (requesters + SRAM)

interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_success;

    logic              vga_re;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_success;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    logic [1:0]        grant;
    logic              timeout_err;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  vga_re, vga_addr,
        input  mem_rdata, mem_done,
        output cpu_rdata, cpu_success,
        output vga_data, vga_success,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output grant, timeout_err
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output vga_re, vga_addr,
        output mem_rdata, mem_done,
        input  cpu_rdata, cpu_success,
        input  vga_data, vga_success,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  grant, timeout_err
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - CPU/VGA arbiter for the single external SRAM port
//
// Purpose: shares one SRAM port between the CPU data bus and the VGA image
//          loader. CPU has fixed priority, but after STARVE_LIMIT consecutive
//          CPU grants with the loader waiting the loader is forced in. One
//          transaction per grant, each bounded by TIMEOUT cycles.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-low reset
//   bus   slave modport of sram_port_arbiter_if (requests, SRAM command,
//         completion strobes, grant, sticky timeout_err)

module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SUCCESS_HOLD = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int HOLD_W   = $clog2(SUCCESS_HOLD + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);

    logic [1:0]          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                cpu_req;

    assign cpu_req = bus.cpu_re | bus.cpu_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_IDLE;
            starve_cnt      <= '0;
            hold_cnt        <= '0;
            wait_cnt        <= '0;
            bus.cpu_rdata   <= '0;
            bus.cpu_success <= 1'b0;
            bus.vga_data    <= '0;
            bus.vga_success <= 1'b0;
            bus.mem_re      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.grant       <= GRANT_NONE;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.vga_re &&
                        (!cpu_req || starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
                        state         <= ST_VGA;
                        bus.grant     <= GRANT_VGA;
                        bus.mem_re    <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.vga_addr;
                        bus.mem_wdata <= '0;
                        starve_cnt    <= '0;
                        wait_cnt      <= WAIT_W'(1);
                    end else if (cpu_req) begin
                        // Write wins when both ops are requested together.
                        state         <= ST_CPU;
                        bus.grant     <= GRANT_CPU;
                        bus.mem_re    <= ~bus.cpu_we;
                        bus.mem_we    <= bus.cpu_we;
                        bus.mem_addr  <= bus.cpu_addr;
                        bus.mem_wdata <= bus.cpu_wdata;
                        wait_cnt      <= WAIT_W'(1);
                        if (bus.vga_re && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                ST_CPU, ST_VGA: begin
                    // wait_cnt is the number of cycles spent in this grant so
                    // far; completion takes precedence over the timeout edge.
                    if (bus.mem_done) begin
                        bus.mem_re <= 1'b0;
                        bus.mem_we <= 1'b0;
                        hold_cnt   <= HOLD_W'(1);
                        state      <= ST_HOLD;
                        if (state == ST_CPU) begin
                            // mem_we is still the latched op during the grant.
                            bus.cpu_rdata   <= bus.mem_we ? '0 : bus.mem_rdata;
                            bus.cpu_success <= 1'b1;
                        end else begin
                            bus.vga_data    <= bus.mem_rdata;
                            bus.vga_success <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        bus.mem_re      <= 1'b0;
                        bus.mem_we      <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        bus.grant       <= GRANT_NONE;
                        state           <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Leaving through IDLE guarantees a low success cycle
                    // before the same requester can complete again.
                    if (hold_cnt == HOLD_W'(SUCCESS_HOLD)) begin
                        bus.cpu_success <= 1'b0;
                        bus.vga_success <= 1'b0;
                        bus.grant       <= GRANT_NONE;
                        hold_cnt        <= '0;
                        state           <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
